// File: rtl/d5m_sensor_pkg.sv
// Shared types and constants for the D5M sensor emulator: FSM states,
// pattern selection, pixel width and the colour-bar step.
package d5m_sensor_pkg;

    localparam int PIX_W       = 12;
    localparam int FRAME_CNT_W = 16;

    // Eight bars spread evenly over the 12-bit range: 7 * 12'h249 = 12'hFFF.
    localparam logic [PIX_W-1:0] BAR_STEP = 12'h249;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        TRAIL  = 3'd4,
        VBLANK = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_CONST   = 2'd3
    } pattern_e;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/d5m_pattern_gen.sv
// Combinational test-pattern source: maps (pattern, column, row, frame count,
// constant) to one 12-bit pixel.
module d5m_pattern_gen
    import d5m_sensor_pkg::*;
#(
    parameter int ACTIVE_COLS = 640,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9
) (
    input  logic [1:0]             pattern_i,
    input  logic [COL_W-1:0]       col_i,
    input  logic [ROW_W-1:0]       row_i,
    input  logic [FRAME_CNT_W-1:0] frame_count_i,
    input  logic [PIX_W-1:0]       const_i,
    output logic [PIX_W-1:0]       pixel_o
);

    localparam int BAR_WIDTH = ACTIVE_COLS / 8;

    logic [15:0]      col_x;
    logic [15:0]      row_x;
    logic [2:0]       bar_idx;
    logic [PIX_W-1:0] ramp_val;

    always_comb begin
        col_x    = 16'(col_i);
        row_x    = 16'(row_i);
        bar_idx  = 3'(col_x / 16'(BAR_WIDTH));
        // Ramp is taken modulo 4096 simply by keeping the low 12 bits.
        ramp_val = PIX_W'(col_x + row_x + frame_count_i);
        pixel_o  = '0;
        case (pattern_e'(pattern_i))
            PAT_BARS:    pixel_o = PIX_W'(bar_idx) * BAR_STEP;
            PAT_RAMP:    pixel_o = ramp_val;
            PAT_CHECKER: pixel_o = (col_x[3] ^ row_x[3]) ? 12'hFFF : 12'h000;
            PAT_CONST:   pixel_o = const_i;
            default:     pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/d5m_sensor_emulator.sv
// Terasic D5M camera emulator: produces FVAL/LVAL/D[11:0] frame timing with
// selectable test patterns, advancing only on pixel-enable ticks.
module d5m_sensor_emulator
    import d5m_sensor_pkg::*;
#(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_BLANK     = 16,
    parameter int FV_LEAD     = 4,
    parameter int FV_TRAIL    = 4,
    parameter int V_BLANK     = 8
) (
    input  logic        piul1FpgaClock,
    input  logic        piul1FpgaReset,
    input  logic        piul1Enable,
    input  logic        piul1PixelEnable,
    input  logic [1:0]  piul2PatternSel,
    input  logic [11:0] piul12ConstValue,
    output logic        poul1FrameValid,
    output logic        poul1LineValid,
    output logic [11:0] poul12PixelData,
    output logic        poul1FrameDone,
    output logic [15:0] poul16FrameCount
);

    localparam int COL_W  = $clog2(ACTIVE_COLS);
    localparam int ROW_W  = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
    localparam int PH_MAX = max_of4(FV_LEAD, H_BLANK, FV_TRAIL, V_BLANK);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    pattern_e               pattern_q, pattern_d;
    logic                   fval_q, fval_d;
    logic                   lval_q, lval_d;
    logic [PIX_W-1:0]       data_q, data_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [PIX_W-1:0]       pixel;
    logic                   frame_end;

    // phase_q counts ticks inside the blanking-type states; col_q/row_q
    // locate the current pixel. Everything below only moves on a tick.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        pattern_d = pattern_q;
        frame_end = 1'b0;

        if (piul1PixelEnable) begin
            case (state_q)
                IDLE: begin
                    if (piul1Enable) begin
                        state_d   = LEAD;
                        phase_d   = '0;
                        col_d     = '0;
                        row_d     = '0;
                        pattern_d = pattern_e'(piul2PatternSel);
                    end
                end
                LEAD: begin
                    if (phase_q == PH_W'(FV_LEAD - 1)) begin
                        state_d = ACTIVE;
                        phase_d = '0;
                        col_d   = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (col_q == COL_W'(ACTIVE_COLS - 1)) begin
                        col_d   = '0;
                        phase_d = '0;
                        state_d = (row_q == ROW_W'(ACTIVE_ROWS - 1)) ? TRAIL : HBLANK;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                HBLANK: begin
                    if (phase_q == PH_W'(H_BLANK - 1)) begin
                        state_d = ACTIVE;
                        phase_d = '0;
                        row_d   = row_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                TRAIL: begin
                    if (phase_q == PH_W'(FV_TRAIL - 1)) begin
                        state_d   = VBLANK;
                        phase_d   = '0;
                        frame_end = 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                VBLANK: begin
                    if (phase_q == PH_W'(V_BLANK - 1)) begin
                        phase_d = '0;
                        if (piul1Enable) begin
                            state_d   = LEAD;
                            row_d     = '0;
                            col_d     = '0;
                            pattern_d = pattern_e'(piul2PatternSel);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register on the
        // same edge as the transition that produces them.
        fval_d        = state_d inside {LEAD, ACTIVE, HBLANK, TRAIL};
        lval_d        = (state_d == ACTIVE);
        data_d        = lval_d ? pixel : '0;
        frame_count_d = frame_end ? frame_count_q + 16'd1 : frame_count_q;
        frame_done_d  = frame_end;
    end

    d5m_pattern_gen #(
        .ACTIVE_COLS (ACTIVE_COLS),
        .COL_W       (COL_W),
        .ROW_W       (ROW_W)
    ) u_pattern_gen (
        .pattern_i     (pattern_d),
        .col_i         (col_d),
        .row_i         (row_d),
        .frame_count_i (frame_count_q),
        .const_i       (piul12ConstValue),
        .pixel_o       (pixel)
    );

    always_ff @(posedge piul1FpgaClock) begin
        if (piul1FpgaReset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pattern_q     <= PAT_BARS;
            fval_q        <= 1'b0;
            lval_q        <= 1'b0;
            data_q        <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            // The done pulse is cleared on every clock, tick or not.
            frame_done_q <= frame_done_d;
            if (piul1PixelEnable) begin
                state_q       <= state_d;
                phase_q       <= phase_d;
                col_q         <= col_d;
                row_q         <= row_d;
                pattern_q     <= pattern_d;
                fval_q        <= fval_d;
                lval_q        <= lval_d;
                data_q        <= data_d;
                frame_count_q <= frame_count_d;
            end
        end
    end

    assign poul1FrameValid  = fval_q;
    assign poul1LineValid   = lval_q;
    assign poul12PixelData  = data_q;
    assign poul1FrameDone   = frame_done_q;
    assign poul16FrameCount = frame_count_q;

endmodule

// File: tb/tb_d5m_sensor_emulator.sv
// Self-checking bench for d5m_sensor_emulator on the small frame configuration,
// comparing every clock against a frame-schedule reference model.
module tb_d5m_sensor_emulator;

  localparam int COLS    = 8;
  localparam int ROWS    = 2;
  localparam int HB      = 2;
  localparam int LEADC   = 1;
  localparam int TRAILC  = 1;
  localparam int VB      = 3;
  localparam int PERIOD  = LEADC + ROWS * COLS + (ROWS - 1) * HB + TRAILC + VB;

  typedef struct packed {
    logic        fv;
    logic        lv;
    logic [11:0] d;
    logic        dn;
    logic [15:0] fc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pix_en;
  logic [1:0]  psel;
  logic [11:0] cval;
  logic        fval;
  logic        lval;
  logic [11:0] data;
  logic        done;
  logic [15:0] fcount;

  vec_t        exp_q[$];
  vec_t        last;
  vec_t        obs;
  logic [15:0] fc_model;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  d5m_sensor_emulator #(
    .ACTIVE_COLS (COLS),
    .ACTIVE_ROWS (ROWS),
    .H_BLANK     (HB),
    .FV_LEAD     (LEADC),
    .FV_TRAIL    (TRAILC),
    .V_BLANK     (VB)
  ) dut (
    .piul1FpgaClock   (clk),
    .piul1FpgaReset   (rst),
    .piul1Enable      (en),
    .piul1PixelEnable (pix_en),
    .piul2PatternSel  (psel),
    .piul12ConstValue (cval),
    .poul1FrameValid  (fval),
    .poul1LineValid   (lval),
    .poul12PixelData  (data),
    .poul1FrameDone   (done),
    .poul16FrameCount (fcount)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic vec_t mk(input logic fv, input logic lv, input logic [11:0] d,
                              input logic dn, input logic [15:0] fc);
    vec_t v;
    v.fv = fv; v.lv = lv; v.d = d; v.dn = dn; v.fc = fc;
    return v;
  endfunction

  function automatic logic [11:0] ref_pixel(input int pat, input int c, input int r,
                                            input int fc, input int cv);
    case (pat)
      0:       return 12'((c / (COLS / 8)) * 'h249);
      1:       return 12'((c + r + fc) % 4096);
      2:       return ((((c >> 3) ^ (r >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return 12'(cv);
    endcase
  endfunction

  // One whole frame, one entry per tick, as seen after each tick edge.
  task automatic push_frame(input int pat, input int cv);
    for (int i = 0; i < LEADC; i++) exp_q.push_back(mk(1'b1, 1'b0, 12'h0, 1'b0, fc_model));
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(mk(1'b1, 1'b1, ref_pixel(pat, c, r, int'(fc_model), cv), 1'b0, fc_model));
      if (r < ROWS - 1)
        for (int h = 0; h < HB; h++) exp_q.push_back(mk(1'b1, 1'b0, 12'h0, 1'b0, fc_model));
    end
    for (int i = 0; i < TRAILC; i++) exp_q.push_back(mk(1'b1, 1'b0, 12'h0, 1'b0, fc_model));
    fc_model = fc_model + 16'd1;
    for (int v = 0; v < VB; v++) exp_q.push_back(mk(1'b0, 1'b0, 12'h0, (v == 0), fc_model));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic pe, output vec_t o);
    pix_en = pe;
    @(negedge clk);
    cyc++;
    o = mk(fval, lval, data, done, fcount);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step(1'b1, obs);
    rst = 1'b0;
    exp_q.delete();
    fc_model = 16'd0;
    last = mk(1'b0, 1'b0, 12'h0, 1'b0, 16'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic pe;
    rst = 1'b1; en = 1'b1; psel = 2'd0; cval = 12'h0;
    for (int k = 0; k < 3; k++) begin
      pe = (k == 1);
      step(pe, obs);
      checks++;
      if (obs !== mk(1'b0, 1'b0, 12'h0, 1'b0, 16'h0)) begin
        errors++;
        $display("FAIL reset_hold k=%0d got %b/%b/%h/%b/%h need all zero", k, obs.fv, obs.lv, obs.d, obs.dn, obs.fc);
      end
    end
    rst = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, obs);
      checks++;
      if (obs !== mk(1'b0, 1'b0, 12'h0, 1'b0, 16'h0)) begin
        errors++;
        $display("FAIL idle_no_enable k=%0d got %b/%b/%h/%b/%h need all zero", k, obs.fv, obs.lv, obs.d, obs.dn, obs.fc);
      end
    end
    fc_model = 16'd0;
    last = mk(1'b0, 1'b0, 12'h0, 1'b0, 16'h0);
  endtask

  task automatic test_timing();
    int fv_hi, lv_hi, dn_cnt, dn_prev, dn_gap;
    fv_hi = 0; lv_hi = 0; dn_cnt = 0; dn_prev = -1; dn_gap = 0;
    psel = 2'd1; cval = 12'h0;
    push_frame(1, 0); push_frame(1, 0);
    en = 1'b1;
    while (exp_q.size() > 0) begin
      if (exp_q.size() < PERIOD) en = 1'b0;
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL timing cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
      fv_hi += int'(obs.fv);
      lv_hi += int'(obs.lv);
      if (obs.dn) begin
        if (dn_prev >= 0) dn_gap = cyc - dn_prev;
        dn_prev = cyc;
        dn_cnt++;
      end
    end
    checks++;
    if (fv_hi != 2 * 20) begin errors++; $display("FAIL timing_fval_clocks got %0d need 40", fv_hi); end
    checks++;
    if (lv_hi != 2 * 16) begin errors++; $display("FAIL timing_lval_clocks got %0d need 32", lv_hi); end
    checks++;
    if (dn_cnt != 2) begin errors++; $display("FAIL timing_done_count got %0d need 2", dn_cnt); end
    checks++;
    if (dn_gap != 23) begin errors++; $display("FAIL timing_done_period got %0d need 23", dn_gap); end
  endtask

  task automatic test_bars();
    logic [11:0] bars [8];
    int col;
    bars = '{12'h000, 12'h249, 12'h492, 12'h6DB, 12'h924, 12'hB6D, 12'hDB6, 12'hFFF};
    col = 0;
    psel = 2'd0; cval = 12'hABC;
    push_frame(0, 'hABC);
    en = 1'b1;
    while (exp_q.size() > 0) begin
      if (exp_q.size() < PERIOD) en = 1'b0;
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL bars cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
      if (obs.lv) begin
        checks++;
        if (col > 7 || obs.d !== bars[col & 7]) begin
          errors++;
          $display("FAIL bars_table col=%0d got %h need %h", col, obs.d, bars[col & 7]);
        end
        col++;
      end else begin
        col = 0;
      end
    end
  endtask

  task automatic test_stall();
    int fv_hi;
    int pat;
    int cv;
    logic pe;
    fv_hi = 0;
    pat = 1; cv = $urandom_range(0, 4095);
    psel = 2'(pat); cval = 12'(cv);
    push_frame(pat, cv);
    en = 1'b1;
    for (int k = 0; exp_q.size() > 0; k++) begin
      if (exp_q.size() < PERIOD) en = 1'b0;
      pe = (k % 2 == 0);
      step(pe, obs);
      if (pe) last = exp_q.pop_front();
      else last.dn = 1'b0;
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL stall cyc=%0d pe=%b got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc, pe,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
      fv_hi += int'(obs.fv);
    end
    checks++;
    if (fv_hi != 40) begin errors++; $display("FAIL stall_fval_clocks got %0d need 40", fv_hi); end
  endtask

  task automatic test_stop_change();
    do_reset();
    psel = 2'd1; cval = 12'h5A5;
    push_frame(1, 'h5A5);
    en = 1'b1;
    for (int k = 0; exp_q.size() > 0; k++) begin
      if (k == 3) en = 1'b0;
      if (k == 5) begin psel = 2'd0; cval = 12'h123; end
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL stop_change cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, obs);
      checks++;
      if (obs !== mk(1'b0, 1'b0, 12'h0, 1'b0, 16'd1)) begin
        errors++;
        $display("FAIL stop_idle k=%0d got %b/%b/%h/%b/%h need 0/0/000/0/0001", k, obs.fv, obs.lv, obs.d, obs.dn, obs.fc);
      end
    end
  endtask

  task automatic test_reset_mid();
    psel = 2'd1; cval = 12'h0;
    push_frame(1, 0);
    en = 1'b1;
    while (exp_q.size() > 0) begin
      if (exp_q.size() < PERIOD) en = 1'b0;
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
    end
    push_frame(1, 0);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL mid_line cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
    end
    rst = 1'b1;
    step(1'b0, obs);
    rst = 1'b0;
    checks++;
    if (obs !== mk(1'b0, 1'b0, 12'h0, 1'b0, 16'h0)) begin
      errors++;
      $display("FAIL reset_mid_line got %b/%b/%h/%b/%h need all zero", obs.fv, obs.lv, obs.d, obs.dn, obs.fc);
    end
    exp_q.delete();
    fc_model = 16'd0;
    push_frame(1, 0);
    while (exp_q.size() > 0) begin
      if (exp_q.size() < PERIOD) en = 1'b0;
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL restart cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
    end
  endtask

  task automatic test_ramp_wrap();
    bit seen_done;
    bit first_px;
    do_reset();
    psel = 2'd1; cval = 12'h0;
    force dut.frame_count_q = 16'hFFFF;
    step(1'b1, obs);
    release dut.frame_count_q;
    step(1'b1, obs);
    checks++;
    if (obs.fc !== 16'hFFFF) begin errors++; $display("FAIL preload got %h need ffff", obs.fc); end
    fc_model = 16'hFFFF;
    last = mk(1'b0, 1'b0, 12'h0, 1'b0, 16'hFFFF);
    push_frame(1, 0); push_frame(1, 0);
    en = 1'b1;
    seen_done = 1'b0; first_px = 1'b1;
    while (exp_q.size() > 0) begin
      if (exp_q.size() < PERIOD) en = 1'b0;
      step(1'b1, obs);
      last = exp_q.pop_front();
      checks++;
      if (obs !== last) begin
        errors++;
        $display("FAIL ramp_wrap cyc=%0d got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", cyc,
                 obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
      end
      if (obs.dn && !seen_done) begin
        seen_done = 1'b1;
        checks++;
        if (obs.fc !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h need 0000", obs.fc); end
      end
      if (seen_done && first_px && obs.lv) begin
        first_px = 1'b0;
        checks++;
        if (obs.d !== 12'h000) begin errors++; $display("FAIL wrap_first_pixel got %h need 000", obs.d); end
      end
    end
  endtask

  task automatic test_random();
    int pat;
    int cv;
    int nfr;
    int guard;
    logic pe;
    for (int it = 0; it < 5; it++) begin
      pat = $urandom_range(0, 3);
      cv  = $urandom_range(0, 4095);
      nfr = $urandom_range(1, 2);
      psel = 2'(pat); cval = 12'(cv);
      for (int f = 0; f < nfr; f++) push_frame(pat, cv);
      en = 1'b1;
      guard = 0;
      while (exp_q.size() > 0) begin
        if (exp_q.size() < PERIOD) en = 1'b0;
        pe = ($urandom_range(0, 3) != 0);
        step(pe, obs);
        if (pe) last = exp_q.pop_front();
        else last.dn = 1'b0;
        checks++;
        if (obs !== last) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d pe=%b got %b/%b/%h/%b/%h need %b/%b/%h/%b/%h", it, cyc, pe,
                   obs.fv, obs.lv, obs.d, obs.dn, obs.fc, last.fv, last.lv, last.d, last.dn, last.fc);
        end
        guard++;
        if (guard > 2000) begin
          errors++;
          $display("FAIL random_budget it=%0d cycles %0d exceeded 2000", it, guard);
          exp_q.delete();
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pix_en = 1'b0; psel = 2'd0; cval = 12'h0;
    fc_model = 16'd0;
    last = mk(1'b0, 1'b0, 12'h0, 1'b0, 16'h0);
    @(negedge clk);
    test_reset();
    test_timing();
    test_bars();
    test_stall();
    test_stop_change();
    test_reset_mid();
    test_ramp_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
